// File: rtl/joker_ep_in_buf.sv
// ---------------------------------------------------------------------------
// joker_ep_in_buf
//
// EP1 IN reply buffer. The control block fills a 2048-byte RAM and commits a
// packet length; the buffer then locks the contents and streams the packet to
// the USB device-core transmit engine on every IN token until the host ACKs
// it. An error handshake or a handshake timeout re-arms the same packet with
// the same data toggle.
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   usb_in_addr/data/wren byte write port into the reply RAM (FILL only)
//   usb_in_commit         commit request level, acted on at its rising edge
//   usb_in_commit_len     packet length sampled at the commit edge
//   usb_in_commit_ack     one-cycle pulse acknowledging the commit
//   usb_in_ready          buffer is free to be written
//   in_token              host requests EP1 data (one-cycle pulse)
//   tx_data/valid/ready   byte stream to the core, valid/ready handshake
//   tx_last               final byte of the packet, qualified by tx_valid
//   tx_zlp                request a zero-length packet (pulse)
//   tx_nak                NAK the current token (pulse)
//   tx_pid1               data toggle, 0 = DATA0, 1 = DATA1
//   host_ack, host_err    host handshake result pulses
// ---------------------------------------------------------------------------
module joker_ep_in_buf #(
  parameter int MAX_PKT    = 512,
  parameter int HS_TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] usb_in_addr,
  input  logic [7:0]  usb_in_data,
  input  logic        usb_in_wren,
  input  logic        usb_in_commit,
  input  logic [10:0] usb_in_commit_len,
  output logic        usb_in_commit_ack,
  output logic        usb_in_ready,
  input  logic        in_token,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic        tx_zlp,
  output logic        tx_nak,
  output logic        tx_pid1,
  input  logic        host_ack,
  input  logic        host_err
);

  typedef enum logic [2:0] {
    S_FILL,
    S_CACK,
    S_PEND,
    S_SEND,
    S_WAIT_HS
  } state_t;

  localparam logic [10:0] MAX_LEN      = 11'(MAX_PKT);
  // The counter starts at 0 on entry to WAIT_HS, so HS_TIMEOUT cycles have
  // elapsed when it holds HS_TIMEOUT-1.
  localparam logic [31:0] TIMEOUT_LAST = 32'(HS_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        commit_q;
  logic [10:0] len_q, len_d;
  logic [10:0] idx_q, idx_d;     // index of the byte currently on tx_data
  logic        valid_q, valid_d;
  logic        pid_q, pid_d;
  logic        nak_q, nak_d;
  logic        zlp_q, zlp_d;
  logic [31:0] cnt_q, cnt_d;

  logic        commit_rise;
  logic        last_byte;
  logic        wr_en;
  logic        rd_en;
  logic [10:0] rd_addr;

  logic [7:0]  ram [0:2047];

  assign commit_rise = usb_in_commit & ~commit_q;
  assign last_byte   = (idx_q == (len_q - 11'd1));

  assign usb_in_ready      = (state_q == S_FILL);
  assign usb_in_commit_ack = (state_q == S_CACK);
  assign tx_valid          = valid_q;
  assign tx_last           = valid_q & last_byte;
  assign tx_zlp            = zlp_q;
  assign tx_nak            = nak_q;
  assign tx_pid1           = pid_q;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    pid_d   = pid_q;
    cnt_d   = '0;
    zlp_d   = 1'b0;
    nak_d   = in_token & ((state_q == S_FILL) | (state_q == S_CACK));
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    rd_addr = idx_q + 11'd1;

    case (state_q)
      S_FILL: begin
        wr_en = usb_in_wren;
        if (commit_rise) begin
          len_d   = (usb_in_commit_len > MAX_LEN) ? MAX_LEN : usb_in_commit_len;
          state_d = S_CACK;
        end
      end

      S_CACK: state_d = S_PEND;

      S_PEND: begin
        if (in_token) begin
          if (len_q == 11'd0) begin
            zlp_d   = 1'b1;
            state_d = S_WAIT_HS;
          end else begin
            idx_d   = '0;
            state_d = S_SEND;
          end
        end
      end

      S_SEND: begin
        if (!valid_q) begin
          // First cycle in SEND: fetch byte 0 into the output register.
          rd_en   = 1'b1;
          rd_addr = '0;
          idx_d   = '0;
          valid_d = 1'b1;
        end else if (tx_ready) begin
          if (last_byte) begin
            valid_d = 1'b0;
            state_d = S_WAIT_HS;
          end else begin
            // Fetch the next byte in the same cycle the current one is
            // accepted, so a held-high tx_ready gives one byte per cycle.
            rd_en = 1'b1;
            idx_d = idx_q + 11'd1;
          end
        end
      end

      S_WAIT_HS: begin
        if (host_ack) begin
          pid_d   = ~pid_q;
          state_d = S_FILL;
        end else if (host_err || (cnt_q == TIMEOUT_LAST)) begin
          state_d = S_PEND;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      default: state_d = S_FILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FILL;
      commit_q <= 1'b0;
      len_q    <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      pid_q    <= 1'b0;
      nak_q    <= 1'b0;
      zlp_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      commit_q <= usb_in_commit;
      len_q    <= len_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      pid_q    <= pid_d;
      nak_q    <= nak_d;
      zlp_q    <= zlp_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: the RAM and its read register are deliberately left out of reset so
  // they map onto a block RAM; tx_data is only meaningful while tx_valid is 1.
  always_ff @(posedge clk) begin
    if (wr_en) ram[usb_in_addr] <= usb_in_data;
    if (rd_en) tx_data <= ram[rd_addr];
  end

endmodule
